// File: rtl/buffet_sram_arb_pkg.sv
// Shared types and default sizes for the buffet SRAM arbiter and its read-data queue.
package buffet_sram_arb_pkg;

    localparam int DEF_DATA_WIDTH   = 64;
    localparam int DEF_ADDR_WIDTH   = 9;
    localparam int DEF_MAX_WR_BURST = 4;

    typedef enum logic {
        ARB_RR      = 1'b0,
        ARB_WR_PRIO = 1'b1
    } arb_mode_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } grant_e;

endpackage

// File: rtl/buffet_rd_fifo2.sv
// Two-entry shift-register FIFO holding SRAM read data; head is always entry 0.
module buffet_rd_fifo2 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = entry0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else if (clk_en) begin
            if (flush) begin
                entry0 <= '0;
                entry1 <= '0;
                count  <= 2'd0;
            end else begin
                case ({push_ok, pop_ok})
                    2'b10: begin
                        if (count == 2'd0) entry0 <= push_data;
                        else               entry1 <= push_data;
                        count <= count + 2'd1;
                    end
                    2'b01: begin
                        entry0 <= entry1;
                        count  <= count - 2'd1;
                    end
                    2'b11: begin
                        // Simultaneous push/pop: the new word lands behind whatever survives the pop.
                        if (count == 2'd1) begin
                            entry0 <= push_data;
                        end else begin
                            entry0 <= entry1;
                            entry1 <= push_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/buffet_sram_arbiter.sv
// Single-port SRAM arbiter for a buffet tile: one access per cycle, round-robin or
// write-priority with a starvation guard, and a credit-checked 2-entry read-data queue.
module buffet_sram_arbiter
    import buffet_sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int MAX_WR_BURST = DEF_MAX_WR_BURST
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic                  arb_mode,
    input  logic                  wr_valid,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_valid,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid,
    input  logic                  rd_data_ready,
    output logic [ADDR_WIDTH-1:0] addr_to_mem,
    output logic [DATA_WIDTH-1:0] data_to_mem,
    output logic                  wen_to_mem,
    output logic                  ren_to_mem,
    input  logic [DATA_WIDTH-1:0] data_from_mem
);

    localparam int BW = $clog2(MAX_WR_BURST + 1);

    // Handshakes: a request transfers in the cycle where valid and ready are both high;
    // ready is the grant and never depends on ready of another interface.
    grant_e          grant;
    grant_e          last_grant;
    logic [BW-1:0]   burst_cnt;
    logic            inflight;
    logic [1:0]      fifo_count;
    logic [1:0]      credit_used;
    logic            fifo_full;
    logic            fifo_empty;
    logic            rd_eligible;

    assign credit_used = fifo_count + {1'b0, inflight};
    assign rd_eligible = rd_valid && !fifo_full && (credit_used < 2'd2);

    always_comb begin
        grant = GNT_NONE;
        if (rst_n && clk_en && !flush) begin
            if (wr_valid && rd_eligible) begin
                if (arb_mode_e'(arb_mode) == ARB_WR_PRIO)
                    grant = (burst_cnt == BW'(MAX_WR_BURST)) ? GNT_RD : GNT_WR;
                else
                    grant = (last_grant == GNT_RD) ? GNT_WR : GNT_RD;
            end else if (wr_valid) begin
                grant = GNT_WR;
            end else if (rd_eligible) begin
                grant = GNT_RD;
            end
        end
    end

    assign wr_ready    = (grant == GNT_WR);
    assign rd_ready    = (grant == GNT_RD);
    assign wen_to_mem  = wr_ready;
    assign ren_to_mem  = rd_ready;
    assign addr_to_mem = wr_ready ? wr_addr : (rd_ready ? rd_addr : '0);
    assign data_to_mem = wr_ready ? wr_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GNT_RD;
            burst_cnt  <= '0;
            inflight   <= 1'b0;
        end else if (clk_en) begin
            if (flush) begin
                last_grant <= GNT_RD;
                burst_cnt  <= '0;
                inflight   <= 1'b0;
            end else begin
                inflight <= (grant == GNT_RD);
                if (grant != GNT_NONE) last_grant <= grant;
                if (grant == GNT_RD || !rd_eligible)
                    burst_cnt <= '0;
                else if (grant == GNT_WR && burst_cnt != BW'(MAX_WR_BURST))
                    burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end

    // The SRAM output holds while clk_en is low, so the in-flight word is captured on the next enabled edge.
    buffet_rd_fifo2 #(.WIDTH(DATA_WIDTH)) u_rd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .flush     (flush),
        .push      (inflight),
        .push_data (data_from_mem),
        .pop       (rd_data_ready),
        .head      (rd_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rd_data_valid = !fifo_empty;

endmodule

// File: tb/tb_buffet_sram_arbiter.sv
// Self-checking bench for buffet_sram_arbiter: SRAM model, directed scenarios and random traffic
// against a transaction-level reference model.
module tb_buffet_sram_arbiter;

    localparam int DW  = 64;
    localparam int AW  = 9;
    localparam int MWB = 4;

    logic          clk = 1'b0;
    logic          rst_n, clk_en, flush, arb_mode;
    logic          wr_valid, rd_valid, rd_data_ready;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready, rd_ready, rd_data_valid, wen_to_mem, ren_to_mem;
    logic [DW-1:0] rd_data, data_to_mem;
    logic [AW-1:0] addr_to_mem;
    logic [DW-1:0] data_from_mem = '0;

    buffet_sram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WR_BURST(MWB)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .arb_mode(arb_mode),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
        .addr_to_mem(addr_to_mem), .data_to_mem(data_to_mem),
        .wen_to_mem(wen_to_mem), .ren_to_mem(ren_to_mem), .data_from_mem(data_from_mem)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- SRAM model ----------------
    logic [DW-1:0] sram [0:511];
    always @(posedge clk) begin
        if (wen_to_mem) sram[addr_to_mem] <= data_to_mem;
        if (ren_to_mem) data_from_mem <= sram[addr_to_mem];
    end

    // ---------------- reference model + scoreboard ----------------
    logic [DW-1:0] mem_m [0:511];
    logic [DW-1:0] exp_q[$];     // read words granted but not yet consumed
    int            arr_q[$];     // enabled-edge count at which each word becomes visible
    int            last_rd;      // 1 when the most recent grant was a read
    int            burst;
    int            ecyc;
    int            last_g;       // 0 none, 1 write, 2 read (model's decision for the last cycle)
    int            n_tests, n_fail;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        arr_q.delete();
        last_rd = 1;
        burst   = 0;
    endtask

    task automatic drive_cycle(input logic ce, input logic fl, input logic wv, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input logic rv, input logic [AW-1:0] ra,
                               input logic rdr);
        int       g;
        bit       rd_el;
        bit       exp_valid;
        logic [DW-1:0] tmp_d;
        int       tmp_i;
        @(negedge clk);
        clk_en = ce; flush = fl; wr_valid = wv; wr_addr = wa; wr_data = wd;
        rd_valid = rv; rd_addr = ra; rd_data_ready = rdr;
        #1;
        rd_el = rv && (exp_q.size() < 2);
        g = 0;
        if (ce && !fl) begin
            if (wv && rd_el) begin
                if (arb_mode) g = (burst == MWB) ? 2 : 1;
                else          g = (last_rd == 1) ? 1 : 2;
            end else if (wv) g = 1;
            else if (rd_el)  g = 2;
        end
        exp_valid = (exp_q.size() > 0) && (arr_q[0] <= ecyc);
        check_eq("wr_ready", 64'(wr_ready), 64'(g == 1));
        check_eq("rd_ready", 64'(rd_ready), 64'(g == 2));
        check_eq("wen", 64'(wen_to_mem), 64'(g == 1));
        check_eq("ren", 64'(ren_to_mem), 64'(g == 2));
        check_eq("addr", 64'(addr_to_mem), (g == 1) ? 64'(wa) : (g == 2) ? 64'(ra) : 64'd0);
        check_eq("wdata", data_to_mem, (g == 1) ? wd : 64'd0);
        check_eq("rd_data_valid", 64'(rd_data_valid), 64'(exp_valid));
        if (exp_valid) check_eq("rd_data", rd_data, exp_q[0]);
        last_g = g;
        if (ce) begin
            if (fl) begin
                model_reset();
            end else begin
                if (exp_valid && rdr) begin
                    tmp_d = exp_q.pop_front();
                    tmp_i = arr_q.pop_front();
                end
                if (g == 1) begin mem_m[wa] = wd; last_rd = 0; end
                if (g == 2) begin exp_q.push_back(mem_m[ra]); arr_q.push_back(ecyc + 2); last_rd = 1; end
                if (g == 2 || !rd_el) burst = 0;
                else if (g == 1)      burst++;
            end
            ecyc++;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_wr_ready"}, 64'(wr_ready), 64'd0);
        check_eq({tag, "_rd_ready"}, 64'(rd_ready), 64'd0);
        check_eq({tag, "_wen"}, 64'(wen_to_mem), 64'd0);
        check_eq({tag, "_ren"}, 64'(ren_to_mem), 64'd0);
        check_eq({tag, "_addr"}, 64'(addr_to_mem), 64'd0);
        check_eq({tag, "_wdata"}, data_to_mem, 64'd0);
        check_eq({tag, "_rd_data"}, rd_data, 64'd0);
        check_eq({tag, "_rd_valid"}, 64'(rd_data_valid), 64'd0);
    endtask

    // Hold reset across edges, idle the requesters, then release on a falling edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        wr_valid = 1'b1; rd_valid = 1'b1; clk_en = 1'b1; flush = 1'b0;
        #1;
        check_outputs_zero("reset");
        wr_valid = 1'b0; rd_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; arb_mode = 1'b0;
        wr_valid = 1'b0; rd_valid = 1'b0; rd_data_ready = 1'b1;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        n_tests = 0; n_fail = 0; ecyc = 0; last_g = 0;
        for (int i = 0; i < 512; i++) begin
            mem_m[i] = {$urandom, $urandom};
            sram[i]  = mem_m[i];
        end
        model_reset();
        apply_reset();

        // Write-only burst
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1, 0, 1, AW'(i), 64'hA0 + 64'(i), 0, '0, 1);
            check_eq("wo_grant", 64'(last_g), 64'd1);
        end

        // Round-robin contention, alternating from write after a flush
        arb_mode = 1'b0;
        drive_cycle(1, 1, 1, '0, '0, 1, '0, 1);
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1, 0, 1, AW'($urandom_range(0, 3)), {$urandom, $urandom}, 1, AW'($urandom_range(0, 3)), 1);
            check_eq("rr_pattern", 64'(last_g), (i % 2 == 0) ? 64'd1 : 64'd2);
        end

        // Write priority: four writes then a forced read
        arb_mode = 1'b1;
        drive_cycle(1, 1, 1, '0, '0, 1, '0, 1);
        for (int i = 0; i < 15; i++) begin
            drive_cycle(1, 0, 1, AW'($urandom_range(0, 3)), {$urandom, $urandom}, 1, AW'($urandom_range(0, 3)), 1);
            check_eq("wp_pattern", 64'(last_g), (i % 5 == 4) ? 64'd2 : 64'd1);
        end

        // Asynchronous reset in the middle of a write burst
        drive_cycle(1, 0, 1, 9'd5, 64'h55, 1, 9'd6, 1);
        @(negedge clk);
        wr_valid = 1'b1; rd_valid = 1'b1; clk_en = 1'b1; flush = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("async_reset");
        apply_reset();

        // Backpressure: exactly two reads until the consumer drains
        arb_mode = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1, 0, 0, '0, '0, 1, AW'(i), 0);
            if (last_g == 2) cnt++;
        end
        check_eq("bp_reads_issued", 64'(cnt), 64'd2);
        check_eq("bp_rd_ready_low", 64'(rd_ready), 64'd0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1, 0, 0, '0, '0, 1, AW'(i + 8), 1);
            if (last_g == 2) cnt++;
        end
        check_eq("bp_reads_resume", 64'(cnt > 0), 64'd1);

        // clk_en low for three cycles with a read in flight
        drive_cycle(1, 1, 0, '0, '0, 0, '0, 1);
        drive_cycle(1, 0, 0, '0, '0, 1, 9'd3, 1);
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, 1, 9'd1, 64'h77, 1, 9'd2, 1);
        for (int i = 0; i < 4; i++) drive_cycle(1, 0, 0, '0, '0, 0, '0, 1);

        // Flush with one queued word and one read in flight
        drive_cycle(1, 0, 0, '0, '0, 1, 9'd10, 0);
        drive_cycle(1, 0, 0, '0, '0, 1, 9'd11, 0);
        drive_cycle(1, 1, 1, 9'd12, 64'h12, 1, 9'd13, 0);
        drive_cycle(1, 0, 1, 9'd12, 64'h1212, 1, 9'd13, 1);
        check_eq("flush_first_write", 64'(last_g), 64'd1);
        check_eq("flush_queue_empty", 64'(rd_data_valid), 64'd0);

        // Random traffic in blocks, each starting with a flush and a fresh mode
        for (int b = 0; b < 6; b++) begin
            arb_mode = 1'($urandom_range(0, 1));
            drive_cycle(1, 1, 0, '0, '0, 0, '0, 1);
            for (int i = 0; i < 60; i++) begin
                drive_cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0),
                            1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), {$urandom, $urandom},
                            1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7));
            end
        end
        for (int i = 0; i < 5; i++) drive_cycle(1, 0, 0, '0, '0, 0, '0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/buffet_sram_arbiter.md
Name: buffet_sram_arbiter

Overview:
- Shares one single-port SRAM (64-bit data, 9-bit address, 1-cycle read latency) between the write path and the read path of a buffet/fiber-access tile.
- Issues at most one memory operation per cycle.
- Arbitrates round-robin or write-priority, with a starvation guard.
- Tracks the in-flight read and buffers read data in a 2-entry credit-checked output queue, so read-side backpressure never loses SRAM data.

Parameters:
- DATA_WIDTH, 64, SRAM word width
- ADDR_WIDTH, 9, SRAM address width
- MAX_WR_BURST, 4, write-priority mode: maximum consecutive write grants while a read is eligible

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  global clock enable; low freezes all state
- flush  in  1  synchronous clear to reset state
- arb_mode  in  1  0 = round-robin, 1 = write-priority (static config)
- wr_valid  in  1  write request
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_ready  out  1  write granted this cycle
- rd_valid  in  1  read request
- rd_addr  in  ADDR_WIDTH  read address
- rd_ready  out  1  read granted this cycle
- rd_data  out  DATA_WIDTH  head of read-data queue
- rd_data_valid  out  1  queue non-empty
- rd_data_ready  in  1  consumer accepts rd_data
- addr_to_mem  out  ADDR_WIDTH  SRAM address
- data_to_mem  out  DATA_WIDTH  SRAM write data
- wen_to_mem  out  1  SRAM write enable
- ren_to_mem  out  1  SRAM read enable
- data_from_mem  in  DATA_WIDTH  SRAM read data, valid the cycle after ren

Behaviour:
- Reset/flush values: all outputs 0; queue empty; in-flight flag 0; last_grant = READ (so the first contended grant goes to write); burst count 0.
- Flush is synchronous and, while clk_en is high, overrides grants in its cycle.
- clk_en low: wr_ready, rd_ready, wen_to_mem and ren_to_mem forced to 0; all registers hold. A pending in-flight capture waits for the next enabled edge, because the SRAM output holds.
- Read eligibility: rd_valid && (occupancy + inflight) < 2, where occupancy is the queue count.
- Grant logic is combinational from registered state; wr_ready/rd_ready equal the grant.
- Only write requested: grant write. Only eligible read: grant read.
- Both requested, arb_mode = 0: grant the requester opposite last_grant.
- Both requested, arb_mode = 1: grant write unless burst count == MAX_WR_BURST, then grant read.
- last_grant updates on every grant.
- Burst count: increments on a write grant while a read is eligible; clears on any read grant or when no read is eligible.
- Memory drive:
  - On write grant: wen = 1, addr = wr_addr, data_to_mem = wr_data.
  - On read grant: ren = 1, addr = rd_addr.
  - Otherwise addr and data_to_mem are 0.
- Read pipeline: inflight <= read grant. When inflight = 1 at an enabled edge, data_from_mem is pushed to the queue.
- Push and pop may occur in the same edge; occupancy is unchanged in that case.
- The credit rule guarantees a push is never dropped: queue full implies no read was issued.
- Ordering: a read granted after a write to the same address returns the new data. The arbiter does not reorder.

Decomposition:
- buffet_sram_arb_pkg: arb_mode_e {ARB_RR, ARB_WR_PRIO}, grant_e {GNT_NONE, GNT_WR, GNT_RD}, default width localparams.
- Sub-module: buffet_rd_fifo2, a 2-entry register FIFO with push, pop, count, full and empty. The arbiter core holds grant logic, burst counter and in-flight tracking.

Test Plan:
- Write-only: addresses 0..3 with data 0xA0..0xA3 -> wen=1 each cycle, addr and data match, wr_ready=1 each cycle, ren never 1.
- Round-robin contention: both valid continuously, arb_mode=0 -> grants alternate W,R,W,R starting with W; rd_data 1 cycle after the ren edge matches the SRAM contents.
- Write-priority starvation: arb_mode=1, both valid, MAX_WR_BURST=4 -> grant pattern W,W,W,W,R repeating.
- Backpressure: rd_data_ready=0, rd_valid=1 -> exactly 2 reads issued, then rd_ready=0; raise rd_data_ready -> both words drained in order, then reads resume.
- clk_en low for 3 cycles with a read in flight -> no grants or enables; data is captured on the first enabled edge and no word is lost.
- Flush mid-operation, queue holding 1 word with a read in flight -> next cycle queue empty, rd_data_valid=0, first contended grant is write.
- Async reset asserted mid-burst -> all outputs 0 immediately, independent of clk.
